// File: rtl/adc_dump_ctrl.sv
// adc_dump_ctrl: streams captured ADC samples from the capture memory to the ADC pads under a divided CLK_RD.
// Build macro ADC_DUMP_LOOP_EN adds a loop_i input for endless repeated dumps (terminated only by abort/reset).
module adc_dump_ctrl #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 14,
  parameter int DIV_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   length_i,
  input  logic [DIV_W-1:0]  clk_div_i,
`ifdef ADC_DUMP_LOOP_EN
  input  logic              loop_i,
`endif
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] adc_data_o,
  output logic              adc_data_valid_o,
  output logic              clk_rd_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, PREFETCH, RUN, DONE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DATA_W-1:0] pref_q;
  logic              loop_q;
  logic              first_q;
  logic              rd_pend_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              clk_rd_q;
  logic              busy_q;
  logic              done_q;

  logic loop_in;
`ifdef ADC_DUMP_LOOP_EN
  assign loop_in = loop_i;
`else
  assign loop_in = 1'b0;
`endif

  logic [DIV_W-1:0]  div_clamp_d;
  logic [ADDR_W:0]   idx_cur_d;
  logic [ADDR_W:0]   idx_new_d;
  logic              wrap_d;
  logic              rd_more_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              tick_d;
  logic              fall_d;
  logic              finish_d;
  logic              launch_d;

  // Half-periods below 2 would leave no room for the one-cycle memory latency between launches.
  assign div_clamp_d = (clk_div_i < DIV_W'(2)) ? DIV_W'(2) : clk_div_i;

  // idx_q == len_q after the last launch; in loop mode that position aliases back to sample 0.
  assign idx_cur_d = (idx_q == len_q) ? '0 : idx_q;
  assign idx_new_d = idx_cur_d + (ADDR_W+1)'(1);
  assign wrap_d    = (idx_new_d == len_q);
  assign rd_more_d = !wrap_d || loop_q;
  assign rd_addr_d = base_q + (wrap_d ? '0 : idx_new_d[ADDR_W-1:0]);

  assign tick_d   = (cnt_q == div_q - DIV_W'(1));
  assign fall_d   = tick_d && clk_rd_q;
  assign finish_d = fall_d && (idx_q == len_q) && !loop_q;
  assign launch_d = first_q || (fall_d && !finish_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      pref_q    <= '0;
      loop_q    <= 1'b0;
      first_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      clk_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (abort_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_en_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      clk_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= rd_en_q;
      if (rd_pend_q) pref_q <= mem_rd_data_i;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (length_i == '0) begin
              state_q <= DONE;
            end else begin
              base_q    <= base_addr_i;
              len_q     <= length_i;
              div_q     <= div_clamp_d;
              loop_q    <= loop_in;
              idx_q     <= '0;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr_i;
              state_q   <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          if (rd_pend_q) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            clk_rd_q <= 1'b0;
            first_q  <= 1'b1;
          end
        end
        RUN: begin
          // The first launch stands in for a falling edge, so the divider holds at 0 for it.
          first_q <= 1'b0;
          if (first_q) begin
            cnt_q <= '0;
          end else if (tick_d) begin
            cnt_q    <= '0;
            clk_rd_q <= ~clk_rd_q;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
          if (launch_d) begin
            data_q  <= pref_q;
            valid_q <= 1'b1;
            idx_q   <= idx_new_d;
            if (rd_more_d) begin
              rd_en_q   <= 1'b1;
              rd_addr_q <= rd_addr_d;
            end
          end
          if (finish_d) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en_o      = rd_en_q;
  assign mem_rd_addr_o    = rd_addr_q;
  assign adc_data_o       = data_q;
  assign adc_data_valid_o = valid_q;
  assign clk_rd_o         = clk_rd_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_adc_dump_ctrl.sv
// tb_adc_dump_ctrl: directed scoreboard bench for adc_dump_ctrl (loop test only when ADC_DUMP_LOOP_EN is defined).
module tb_adc_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [13:0] baseAddr;
  logic [14:0] length;
  logic [7:0]  clkDiv;
  logic        loopSel;
  logic        rdEn;
  logic [13:0] rdAddr;
  logic [17:0] rdData = '0;
  logic [17:0] adcData;
  logic        valid;
  logic        clkRd;
  logic        busy;
  logic        done;

  adc_dump_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .abort_i          (abort),
    .base_addr_i      (baseAddr),
    .length_i         (length),
    .clk_div_i        (clkDiv),
`ifdef ADC_DUMP_LOOP_EN
    .loop_i           (loopSel),
`endif
    .mem_rd_en_o      (rdEn),
    .mem_rd_addr_o    (rdAddr),
    .mem_rd_data_i    (rdData),
    .adc_data_o       (adcData),
    .adc_data_valid_o (valid),
    .clk_rd_o         (clkRd),
    .busy_o           (busy),
    .done_o           (done)
  );

  always #5 clk = ~clk;

  // Capture memory: word at address a holds 0x3F000 + a (truncated to 18 bits), one-cycle read latency.
  always @(posedge clk) begin
    if (rdEn) rdData <= 18'h3F000 + {4'b0000, rdAddr};
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  int unsigned expAddrQ[$];
  int unsigned expDataQ[$];
  int expPeriod = 0;

  int cyc = 0;
  int lastLaunch = 0;
  int launches = 0;
  int validCycles = 0;
  int clkRdHigh = 0;
  int doneCount = 0;
  int doneCyc = 0;
  int lastFall = 0;
  logic prevValid = 1'b0;
  logic prevClkRd = 1'b0;
  logic [17:0] prevData = '0;

  // Monitor: pops the scoreboard on every read strobe and every sample launch.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (rdEn) begin
        if (expAddrQ.size() == 0) checkOutput("read_unexpected", rdAddr, 32'hFFFF_FFFF);
        else checkOutput("read_addr", rdAddr, expAddrQ.pop_front());
      end
      if (valid && (!prevValid || (prevClkRd && !clkRd))) begin
        if (expDataQ.size() == 0) checkOutput("launch_unexpected", adcData, 32'hFFFF_FFFF);
        else checkOutput("launch_data", adcData, expDataQ.pop_front());
        if (prevValid) checkOutput("launch_period", cyc - lastLaunch, expPeriod);
        lastLaunch = cyc;
        launches++;
      end
      if (valid && prevValid && adcData != prevData && !(prevClkRd && !clkRd))
        checkOutput("data_edge", adcData, prevData);
      if (valid) validCycles++;
      if (clkRd) clkRdHigh++;
      if (prevClkRd && !clkRd) lastFall = cyc;
      if (done) begin
        doneCount++;
        doneCyc = cyc;
      end
    end
    prevValid = valid;
    prevClkRd = clkRd;
    prevData  = adcData;
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic pushExp(input int unsigned a, input int unsigned d);
    expAddrQ.push_back(a);
    expDataQ.push_back(d);
  endtask

  int startEdge = 0;

  task automatic applyStimulus(input int unsigned b, input int unsigned n, input int unsigned dv,
                               input logic lp, input int period);
    baseAddr    = 14'(b);
    length      = 15'(n);
    clkDiv      = 8'(dv);
    loopSel     = lp;
    expPeriod   = period;
    launches    = 0;
    validCycles = 0;
    clkRdHigh   = 0;
    doneCount   = 0;
    start       = 1'b1;
    startEdge   = cyc + 1;
    cycle();
    start = 1'b0;
  endtask

  task automatic waitIdle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      cycle();
      k++;
    end
    if (busy) checkOutput("idle_timeout", 1, 0);
    cycle();
  endtask

  task automatic waitLaunches(input int n, input int maxc);
    int k = 0;
    while (launches < n && k < maxc) begin
      cycle();
      k++;
    end
    if (launches < n) checkOutput("launch_timeout", launches, n);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; loopSel = 1'b0;
    baseAddr = '0; length = '0; clkDiv = '0;
    repeat (3) cycle();
    checkOutput("reset_rd_en", rdEn, 0);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_clk_rd", clkRd, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_data", adcData, 0);
    rst = 1'b0;
    cycle();

    $display("[TB] basic dump");
    pushExp('h0010, 'h3F010); pushExp('h0011, 'h3F011);
    pushExp('h0012, 'h3F012); pushExp('h0013, 'h3F013);
    applyStimulus('h0010, 4, 3, 1'b0, 6);
    waitIdle(200);
    checkOutput("basic_launches", launches, 4);
    checkOutput("basic_valid_cycles", validCycles, 24);
    checkOutput("basic_clk_rd_high", clkRdHigh, 12);
    checkOutput("basic_done_count", doneCount, 1);
    checkOutput("basic_done_timing", doneCyc - lastFall, 1);
    checkOutput("basic_reads_left", expAddrQ.size(), 0);
    checkOutput("basic_clk_rd_end", clkRd, 0);

    $display("[TB] divider clamp");
    pushExp('h0100, 'h3F100); pushExp('h0101, 'h3F101); pushExp('h0102, 'h3F102);
    applyStimulus('h0100, 3, 0, 1'b0, 4);
    waitIdle(200);
    checkOutput("clamp0_launches", launches, 3);
    checkOutput("clamp0_valid_cycles", validCycles, 12);
    checkOutput("clamp0_clk_rd_high", clkRdHigh, 6);
    pushExp('h0140, 'h3F140); pushExp('h0141, 'h3F141); pushExp('h0142, 'h3F142);
    applyStimulus('h0140, 3, 1, 1'b0, 4);
    waitIdle(200);
    checkOutput("clamp1_launches", launches, 3);
    checkOutput("clamp1_clk_rd_high", clkRdHigh, 6);
    checkOutput("clamp1_done_count", doneCount, 1);

    $display("[TB] zero length");
    applyStimulus('h0050, 0, 5, 1'b0, 0);
    waitIdle(50);
    checkOutput("zero_done_count", doneCount, 1);
    checkOutput("zero_done_timing", doneCyc - startEdge, 1);
    checkOutput("zero_launches", launches, 0);
    checkOutput("zero_clk_rd_high", clkRdHigh, 0);

    $display("[TB] address wrap");
    pushExp('h3FFE, 'h02FFE); pushExp('h3FFF, 'h02FFF);
    pushExp('h0000, 'h3F000); pushExp('h0001, 'h3F001);
    applyStimulus('h3FFE, 4, 2, 1'b0, 4);
    waitIdle(200);
    checkOutput("wrap_launches", launches, 4);
    checkOutput("wrap_reads_left", expAddrQ.size(), 0);

    $display("[TB] abort and restart");
    pushExp('h0200, 'h3F200); pushExp('h0201, 'h3F201);
    expAddrQ.push_back('h0202);
    applyStimulus('h0200, 8, 2, 1'b0, 4);
    waitLaunches(1, 50);
    baseAddr = 14'h0300; length = 15'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    waitLaunches(2, 50);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checkOutput("abort_valid", valid, 0);
    checkOutput("abort_clk_rd", clkRd, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_rd_en", rdEn, 0);
    checkOutput("abort_data", adcData, 0);
    repeat (4) cycle();
    checkOutput("abort_done_count", doneCount, 0);
    checkOutput("abort_launches", launches, 2);
    checkOutput("abort_reads_left", expAddrQ.size(), 0);
    pushExp('h0020, 'h3F020); pushExp('h0021, 'h3F021); pushExp('h0022, 'h3F022);
    applyStimulus('h0020, 3, 3, 1'b0, 6);
    waitIdle(200);
    checkOutput("restart_launches", launches, 3);
    checkOutput("restart_done_count", doneCount, 1);
    checkOutput("restart_data_left", expDataQ.size(), 0);

`ifdef ADC_DUMP_LOOP_EN
    $display("[TB] loop mode");
    pushExp('h0400, 'h3F400); pushExp('h0401, 'h3F401); pushExp('h0402, 'h3F402);
    pushExp('h0400, 'h3F400); pushExp('h0401, 'h3F401); pushExp('h0402, 'h3F402);
    pushExp('h0400, 'h3F400);
    expAddrQ.push_back('h0401);
    applyStimulus('h0400, 3, 2, 1'b1, 4);
    waitLaunches(7, 100);
    checkOutput("loop_valid_no_gap", validCycles, 25);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checkOutput("loop_abort_valid", valid, 0);
    checkOutput("loop_abort_busy", busy, 0);
    repeat (4) cycle();
    checkOutput("loop_done_count", doneCount, 0);
    checkOutput("loop_reads_left", expAddrQ.size(), 0);
    loopSel = 1'b0;
`endif

    checkOutput("final_data_left", expDataQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_dump_ctrl.md
Name: adc_dump_ctrl

Overview:
- Sequencer that streams captured ADC samples from the on-chip capture memory out to the ADC_DATA/ADC_DATA_VALID/CLK_RD pad outputs.
- Sits between the capture SRAM read port and the pad ring.
- Generates the divided read clock CLK_RD and launches one 18-bit sample per CLK_RD period.
- Started and aborted from MDIO-mapped control registers.

Parameters:
- DATA_W, 18, sample width (matches ADC_DATA pad count).
- ADDR_W, 14, capture memory address width.
- DIV_W, 8, width of the CLK_RD half-period divider.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a dump when idle.
- abort  in  1  level/pulse; terminates a dump.
- base_addr  in  ADDR_W  first memory address.
- length  in  ADDR_W+1  sample count; 0 to 2^ADDR_W.
- clk_div  in  DIV_W  CLK_RD half-period in clk cycles.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- adc_data  out  DATA_W  to pad ADC_DATA.
- adc_data_valid  out  1  to pad ADC_DATA_VALID.
- clk_rd  out  1  to pad CLK_RD.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Clocking/reset: one clock, clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE; divider, index and prefetch registers cleared.
- FSM states: IDLE, PREFETCH, RUN, DONE.
- IDLE + start:
  - length==0: go to DONE; no memory reads; clk_rd stays 0.
  - length!=0: latch base_addr, length and div = max(clk_div, 2) (values 0/1 clamp to 2). Next cycle: mem_rd_en=1, mem_rd_addr=base; enter PREFETCH.
- start while busy: ignored.
- PREFETCH: the cycle after the read, capture mem_rd_data into the prefetch register; enter RUN with clk_rd=0 and div_cnt=0.
- RUN divider:
  - div_cnt counts 0..div-1. At div-1, clk_rd toggles and div_cnt returns to 0.
  - CLK_RD period = 2*div clk cycles; 50% duty.
- Launch event: first RUN cycle, then every falling toggle of clk_rd. On launch:
  - adc_data <= prefetch; adc_data_valid <= 1; index++.
  - If samples remain: in the next cycle mem_rd_en=1, mem_rd_addr=base+index (mod 2^ADDR_W). Data is captured into prefetch one cycle later, always before the next launch (div>=2).
- Data-edge relationship: adc_data changes only coincident with clk_rd falling, so it is stable around the clk_rd rising edge (external capture edge).
- Last sample: clk_rd keeps toggling until the falling edge after the last launch. At that edge: adc_data_valid<=0, adc_data<=0, clk_rd remains 0; enter DONE.
- DONE: done=1 for one cycle; return to IDLE.
- Read count: exactly length reads per dump. Address wraps modulo 2^ADDR_W if base+length exceeds depth.
- Abort (any non-IDLE state, including the start cycle): next cycle adc_data_valid=0, adc_data=0, clk_rd=0, mem_rd_en=0; state IDLE; done not pulsed. Abort has priority over start.
- rst mid-dump: identical to abort plus all registers return to reset values.
- Configuration inputs are sampled only at accepted start; changes during a dump have no effect.

Optional Feature:
- Macro ADC_DUMP_LOOP_EN.
- Defined: extra input port loop (1 bit), latched at start.
  - loop=1: after the last sample, index wraps to 0 and launches continue seamlessly (no gap in clk_rd or valid), reading from base again.
  - Terminates only on abort or rst; done never pulses.
  - length==0 with loop=1 behaves as the non-loop case (immediate done).
- Undefined: no loop port; behaviour as above.

Test Plan:
- Basic dump: base=0x0010, length=4, clk_div=3, memory[i]=0x3F000+i -> four launches at 6-cycle spacing with adc_data 0x3F010..0x3F013; valid high for 24 clk cycles; exactly 4 reads at 0x0010..0x0013; done pulses once, 1 cycle after the final clk_rd fall.
- Divider clamp: clk_div=0 and clk_div=1, length=3 -> clk_rd period 4 cycles in both cases; adc_data transitions only coincide with clk_rd falling edges.
- Zero length: start with length=0 -> done pulses the cycle after IDLE->DONE; no mem_rd_en, clk_rd and valid stay 0.
- Address wrap: base=0x3FFE, length=4 -> read addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001 in order.
- Abort/restart: abort after the 2nd launch of a length=8 dump; start pulsed while busy before abort -> start ignored; 1 cycle after abort valid=0, clk_rd=0, busy=0, no done; a new start then runs a full, correct dump.
- Loop (ADC_DUMP_LOOP_EN): loop=1, length=3, clk_div=2 -> sample sequence d0,d1,d2,d0,d1,... with a constant 4-cycle period and no valid gap; abort stops it cleanly, no done.
